// File: rtl/mux_select_sequencer.sv
// Select-line sequencer for a downstream 4x1 mux: round-robin auto scan with dwell, or manual select.
// Optional feature: define MUX_SEQ_SKIP_EN to honour ch_mask; otherwise all four channels are always scanned.
module mux_select_sequencer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [1:0]         man_sel,
  input  logic [3:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               S1,
  output logic               S0,
  output logic               sel_valid,
  output logic               busy,
  output logic               ch_change,
  output logic               scan_done
);

  typedef enum logic [1:0] {IDLE, SCAN, MANUAL} state_t;

  state_t             state, state_nx;
  logic [1:0]         sel, sel_nx;
  logic [DWELL_W-1:0] cnt, cnt_nx;
  logic               valid_nx, busy_nx, chg_nx, done_nx;
  logic [3:0]         eff_mask;
  logic [1:0]         lowest, next_up;

`ifdef MUX_SEQ_SKIP_EN
  assign eff_mask = ch_mask;
`else
  logic unused_mask;
  assign eff_mask    = '1;
  assign unused_mask = ^ch_mask;
`endif

  assign S1 = sel[1];
  assign S0 = sel[0];

  // Search downward so the lowest index / smallest forward offset wins.
  // Offset 4 wraps back to the current channel, covering the single-channel case.
  always_comb begin
    logic [1:0] cand;
    lowest  = '0;
    next_up = sel;
    cand    = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (eff_mask[i-1]) lowest = 2'(i - 1);
    end
    for (int unsigned k = 4; k > 0; k--) begin
      cand = sel + 2'(k);
      if (eff_mask[cand]) next_up = cand;
    end
  end

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    cnt_nx   = cnt;
    valid_nx = sel_valid;
    busy_nx  = busy;
    chg_nx   = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        sel_nx   = '0;
        cnt_nx   = '0;
        valid_nx = 1'b0;
        busy_nx  = 1'b0;
        if (start && !stop) begin
          if (mode) begin
            state_nx = MANUAL;
            sel_nx   = man_sel;
            valid_nx = 1'b1;
            busy_nx  = 1'b1;
            chg_nx   = 1'b1;
          end else if (|eff_mask) begin
            state_nx = SCAN;
            sel_nx   = lowest;
            valid_nx = 1'b1;
            busy_nx  = 1'b1;
            chg_nx   = 1'b1;
          end
        end
      end
      SCAN: begin
        if (stop || eff_mask == '0) begin
          state_nx = IDLE;
          sel_nx   = '0;
          cnt_nx   = '0;
          valid_nx = 1'b0;
          busy_nx  = 1'b0;
        end else if (cnt == dwell) begin
          sel_nx  = next_up;
          cnt_nx  = '0;
          chg_nx  = (next_up != sel);
          done_nx = (next_up <= sel);
        end else begin
          cnt_nx = cnt + DWELL_W'(1);
        end
      end
      MANUAL: begin
        if (stop) begin
          state_nx = IDLE;
          sel_nx   = '0;
          cnt_nx   = '0;
          valid_nx = 1'b0;
          busy_nx  = 1'b0;
        end else begin
          sel_nx = man_sel;
          chg_nx = (man_sel != sel);
        end
      end
      default: begin
        state_nx = IDLE;
        sel_nx   = '0;
        cnt_nx   = '0;
        valid_nx = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      cnt       <= '0;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
      ch_change <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      state     <= state_nx;
      sel       <= sel_nx;
      cnt       <= cnt_nx;
      sel_valid <= valid_nx;
      busy      <= busy_nx;
      ch_change <= chg_nx;
      scan_done <= done_nx;
    end
  end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench for mux_select_sequencer: a behavioural channel model checked every cycle,
// plus literal sequences that pin the model for the main scan and manual scenarios.
module tb_mux_select_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, mode;
  logic [1:0] man_sel;
  logic [3:0] ch_mask;
  logic [7:0] dwell;
  logic       S1, S0, sel_valid, busy, ch_change, scan_done;

  int n_checks = 0;
  int n_fail   = 0;

  mux_select_sequencer #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .man_sel(man_sel), .ch_mask(ch_mask), .dwell(dwell),
    .S1(S1), .S0(S0), .sel_valid(sel_valid), .busy(busy),
    .ch_change(ch_change), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which channel is routed, how long it has been held, and which mode we are in.
  int   m_mode;  // 0 idle, 1 scan, 2 manual
  int   m_ch, m_age;
  bit   m_valid, m_busy, m_chg, m_done, m_known;

  function automatic int unsigned eff_mask();
`ifdef MUX_SEQ_SKIP_EN
    return int'(ch_mask);
`else
    return 15;
`endif
  endfunction

  task automatic model_idle();
    m_mode = 0; m_ch = 0; m_age = 0;
    m_valid = 0; m_busy = 0; m_chg = 0; m_done = 0;
  endtask

  always @(posedge clk) begin
    int unsigned em;
    int nxt;
    bit found;
    em = eff_mask();
    if (rst) begin
      model_idle();
      m_known = 1;
    end else if (m_mode == 0) begin
      model_idle();
      if (start && !stop) begin
        if (mode) begin
          m_mode = 2; m_ch = int'(man_sel); m_valid = 1; m_busy = 1; m_chg = 1;
        end else if (em != 0) begin
          found = 0;
          for (int c = 0; c < 4; c++)
            if (!found && em[c]) begin m_ch = c; found = 1; end
          m_mode = 1; m_age = 0; m_valid = 1; m_busy = 1; m_chg = 1;
        end
      end
    end else if (m_mode == 1) begin
      m_chg = 0; m_done = 0;
      if (stop || em == 0) model_idle();
      else if (m_age == int'(dwell)) begin
        nxt = m_ch; found = 0;
        for (int k = 1; k <= 4; k++)
          if (!found && em[(m_ch + k) % 4]) begin nxt = (m_ch + k) % 4; found = 1; end
        m_chg  = (nxt != m_ch);
        m_done = (nxt <= m_ch);
        m_ch   = nxt;
        m_age  = 0;
      end else m_age++;
    end else begin
      m_done = 0;
      if (stop) model_idle();
      else begin
        m_chg = (int'(man_sel) != m_ch);
        m_ch  = int'(man_sel);
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] ch2;
    if (m_known) begin
      ch2 = 2'(m_ch);
      check("model", {2'b00, S1, S0, sel_valid, busy, ch_change, scan_done},
            {2'b00, ch2, m_valid, m_busy, m_chg, m_done});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input logic m);
    mode = m; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  int exp_s[13]    = '{0,0,0,1,1,1,2,2,2,3,3,3,0};
  int exp_chg[13]  = '{1,0,0,1,0,0,1,0,0,1,0,0,1};
  int exp_done[13] = '{0,0,0,0,0,0,0,0,0,0,0,0,1};
`ifdef MUX_SEQ_SKIP_EN
  int alt_s[4]    = '{1,3,1,3};
  int alt_done[4] = '{0,0,1,0};
`else
  int ns_s[9]    = '{0,0,1,1,2,2,3,3,0};
  int ns_done[9] = '{0,0,0,0,0,0,0,0,1};
`endif

  initial begin
    m_known = 0;
    rst = 1; start = 0; stop = 0; mode = 0;
    man_sel = 0; ch_mask = 4'hF; dwell = 0;
    tick(2);
    rst = 0;
    repeat (5) begin
      @(negedge clk);
      check("reset_idle", {2'b00, S1, S0, sel_valid, busy, ch_change, scan_done}, 8'h00);
    end
    @(posedge clk); #2;

    // Auto scan, dwell=2, all channels enabled.
    dwell = 2; ch_mask = 4'hF;
    pulse_start(1'b0);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      check("scan_sel",  {6'b0, S1, S0}, 8'(exp_s[i]));
      check("scan_chg",  {7'b0, ch_change}, 8'(exp_chg[i]));
      check("scan_done", {7'b0, scan_done}, 8'(exp_done[i]));
    end
    @(posedge clk); #2;
    do_stop();
    tick(1);

`ifdef MUX_SEQ_SKIP_EN
    // Empty-mask start stays idle.
    ch_mask = 4'h0;
    pulse_start(1'b0);
    @(negedge clk);
    check("empty_start", {6'b0, busy, sel_valid}, 8'h00);
    @(posedge clk); #2;
    // Alternating 1,3 with dwell=0.
    dwell = 0; ch_mask = 4'b1010;
    pulse_start(1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("alt_sel",  {6'b0, S1, S0}, 8'(alt_s[i]));
      check("alt_done", {7'b0, scan_done}, 8'(alt_done[i]));
    end
    @(posedge clk); #2;
    ch_mask = 4'h0;
    tick(1);
    @(negedge clk);
    check("mask_empty_idle", {6'b0, sel_valid, busy}, 8'h00);
    @(posedge clk); #2;
    // Single enabled channel: constant select, periodic scan_done.
    ch_mask = 4'b0100; dwell = 1;
    pulse_start(1'b0);
    tick(6);
    // Current channel masked mid-hold.
    ch_mask = 4'b1001;
    tick(5);
    do_stop();
`else
    // Mask is ignored in this build.
    ch_mask = 4'b0001; dwell = 1;
    pulse_start(1'b0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("ns_sel",  {6'b0, S1, S0}, 8'(ns_s[i]));
      check("ns_done", {7'b0, scan_done}, 8'(ns_done[i]));
    end
    @(posedge clk); #2;
    do_stop();
    ch_mask = 4'hF;
`endif
    tick(1);

    // Manual: 2 -> 2 -> 1.
    man_sel = 2'd2;
    pulse_start(1'b1);
    @(negedge clk);
    check("man_first", {6'b0, S1, S0}, 8'd2);
    check("man_first_chg", {7'b0, ch_change}, 8'd1);
    @(posedge clk); #2;
    mode = 0;  // ignored outside IDLE
    man_sel = 2'd1;
    @(negedge clk);
    check("man_hold_chg", {7'b0, ch_change}, 8'd0);
    @(posedge clk); #2;
    @(negedge clk);
    check("man_second", {6'b0, S1, S0}, 8'd1);
    check("man_second_chg", {7'b0, ch_change}, 8'd1);
    @(posedge clk); #2;
    ch_mask = 4'h0; dwell = 0;
    tick(3);
    ch_mask = 4'hF;
    do_stop();
    tick(1);

    // Dwell change mid-hold, then stop+start together during scan.
    dwell = 5;
    pulse_start(1'b0);
    tick(2);
    dwell = 1;
    tick(5);
    stop = 1; start = 1;
    tick(1);
    stop = 0; start = 0;
    @(negedge clk);
    check("stop_start_scan", {2'b00, S1, S0, sel_valid, busy, ch_change, scan_done}, 8'h00);
    @(posedge clk); #2;
    stop = 1; start = 1;
    tick(1);
    stop = 0; start = 0;
    @(negedge clk);
    check("stop_start_idle", {7'b0, busy}, 8'h00);
    @(posedge clk); #2;

    // rst mid-scan overrides start.
    dwell = 3;
    pulse_start(1'b0);
    tick(5);
    rst = 1; start = 1;
    tick(1);
    @(negedge clk);
    check("rst_mid_scan", {2'b00, S1, S0, sel_valid, busy, ch_change, scan_done}, 8'h00);
    @(posedge clk); #2;
    rst = 0; start = 0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_select_sequencer.md
# mux_select_sequencer

Synchronous select-line generator that drives the S1/S0 inputs of the 4x1 multiplexer stage directly downstream. In auto mode it scans channels E0..E3 round-robin, holding each for a programmable dwell time and skipping masked channels. In manual mode it forwards a registered channel number. It also flags channel changes and scan wrap-around so the consumer of Y knows which input is currently routed.

## Interface
- DWELL_W, 8, width of the dwell-count input and the internal dwell counter

- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous, active-high reset
- start  input  1  begin operation in the mode given by `mode`; sampled in IDLE only
- stop  input  1  return to IDLE; has priority over start
- mode  input  1  0 = auto scan, 1 = manual; sampled with start
- man_sel  input  2  manual channel number {S1,S0}
- ch_mask  input  4  per-channel enable, bit i = channel Ei
- dwell  input  DWELL_W  hold count; each channel is held dwell+1 cycles
- S1  output  1  select MSB to the mux
- S0  output  1  select LSB to the mux
- sel_valid  output  1  S1/S0 currently route a valid channel
- busy  output  1  not in IDLE
- ch_change  output  1  one-cycle pulse in the first cycle a new select value is driven
- scan_done  output  1  one-cycle pulse when the auto scan wraps to a lower channel index

## Operation
- States: IDLE, SCAN, MANUAL. All outputs are registered.
- Reset: state IDLE, {S1,S0}=00, sel_valid=0, busy=0, ch_change=0, scan_done=0, dwell counter=0.
- IDLE behaviour:
  - Outputs hold {S1,S0}=00 with sel_valid=0.
  - start=1, stop=0, mode=0: go to SCAN. Load the lowest enabled channel index, counter=0, sel_valid=1, ch_change=1.
  - start=1, stop=0, mode=1: go to MANUAL. Load man_sel, sel_valid=1, ch_change=1.
  - start with an empty effective mask in auto mode: stay in IDLE, no pulses.
- SCAN behaviour:
  - The counter increments each cycle.
  - When counter equals dwell, advance to the next enabled channel above the current one, wrapping 3->0. At the same time reset the counter and pulse ch_change.
  - dwell is sampled every cycle; changing it mid-hold takes effect at the next compare.
  - If the advance wraps (new index <= old index), pulse scan_done in the same cycle as ch_change.
  - With exactly one enabled channel: {S1,S0} stays constant, ch_change stays 0, and scan_done pulses every dwell+1 cycles.
  - If the current channel gets masked, it still finishes its dwell and is then skipped.
  - If the effective mask becomes 0000: go to IDLE next cycle, {S1,S0}=00, sel_valid=0, no pulses.
- MANUAL behaviour:
  - {S1,S0} follows man_sel with one cycle of latency.
  - ch_change pulses only when the registered value changes.
  - ch_mask and dwell are ignored; scan_done stays 0.
- From any state: stop=1 goes to IDLE next cycle, with outputs at their reset values.
- mode changes outside IDLE are ignored until the next start.

## Timing
- start sampled at edge k: select, sel_valid, busy and ch_change are visible after edge k, so the mux's Y is valid in cycle k+1.
- Channel hold time in SCAN is exactly dwell+1 cycles, including the first entry.
- ch_change and scan_done are one clock wide and coincide with the first cycle of the new select.
- rst asserted mid-operation takes effect at the next edge and overrides stop and start.
- stop and start asserted together in IDLE: the block stays in IDLE.

## Configuration
- MUX_SEQ_SKIP_EN defined:
  - ch_mask is honoured as described above.
- MUX_SEQ_SKIP_EN undefined:
  - The effective mask is hard-wired to 1111 and the ch_mask input is unused.
  - SCAN always cycles 0,1,2,3, with scan_done on every 3->0 transition.
  - The empty-mask paths are unreachable.

## Test plan
- Reset, then idle for 5 cycles -> {S1,S0}=00, sel_valid=0, busy=0, no pulses.
- Auto, dwell=2, mask=1111, start 1 cycle -> sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. ch_change on each first cycle; scan_done at the 3->0 step.
- Auto, dwell=0, mask=1010 (skip build) -> alternate 1,3,1,3 every cycle, scan_done at each 3->1 step. Then set mask=0000 -> IDLE next cycle, sel_valid=0.
- Manual, man_sel 2 -> 2 -> 1 -> {S1,S0}=10 one cycle after start, ch_change once. Then 01 one cycle after the change, with a second ch_change.
- During a SCAN hold, assert stop and start together -> IDLE next cycle, outputs at reset values. Assert rst mid-scan -> reset values next cycle, with rst taking priority.
- Non-skip build, mask=0001, auto, dwell=1 -> full 0,1,2,3 cycle at two cycles per channel, ignoring the mask.
